// File: rtl/compression_pkg.sv
// Shared types and defaults for the compression pipeline sequencing controller.
package compression_pkg;

  localparam int IMG_SEL_W      = 3;
  localparam int DRAIN_IDLE_DEF = 64;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } comp_ctrl_state_t;

endpackage

// File: rtl/compression_wr_addr_gen.sv
// Compressed-memory write port: registered strobe/address/data, saturating
// write pointer and word count, sticky overflow once the memory is full.
module compression_wr_addr_gen
  import compression_pkg::*;
#(
  parameter int AHB_WIDTH  = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [AHB_WIDTH-1:0]  i_data,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [AHB_WIDTH-1:0]  o_mem_wdata,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overflow
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_full;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [AHB_WIDTH-1:0]  r_wdata;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_full   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_clear) begin
        r_wr_ptr <= '0;
        r_full   <= 1'b0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else if (i_wr_en) begin
        if (r_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_wr_ptr;
          r_wdata <= i_data;
          r_count <= r_count + CW'(1);
          // The pointer parks on the last address; r_full marks it as consumed.
          if (r_wr_ptr == '1) r_full <= 1'b1;
          else                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_word_count = r_count;
  assign o_overflow   = r_ovf;

endmodule

// File: rtl/compression_ctrl.sv
// Job sequencer for the compression pipeline: start/abort handling, pipeline
// enable/flush, block counting with timeout, drain detection and job reporting.
module compression_ctrl
  import compression_pkg::*;
#(
  parameter int AHB_WIDTH  = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLK_WIDTH  = 8,
  parameter int DRAIN_IDLE = DRAIN_IDLE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [IMG_SEL_W-1:0]  i_img_sel,
  input  logic [BLK_WIDTH-1:0]  i_num_blocks,
  input  logic                  i_blk_valid,
  input  logic                  i_pipe_valid,
  input  logic [AHB_WIDTH-1:0]  i_pipe_data,
  output logic                  o_pipe_enable,
  output logic                  o_pipe_flush,
  output logic [IMG_SEL_W-1:0]  o_pipe_img_sel,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [AHB_WIDTH-1:0]  o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_irq,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_err_overflow,
  output logic                  o_err_timeout,
  output comp_ctrl_state_t      o_dbg_state
);

  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);

  comp_ctrl_state_t     r_state;
  logic [BLK_WIDTH-1:0] r_num_blocks;
  logic [BLK_WIDTH-1:0] r_blk_cnt;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [IDLE_W-1:0]    r_idle_cnt;
  logic                 r_flush_cnt;
  logic                 r_pipe_enable;
  logic                 r_pipe_flush;
  logic [IMG_SEL_W-1:0] r_img_sel;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_irq;
  logic                 r_err_timeout;

  logic                 w_accept;
  logic                 w_abort;
  logic                 w_wr_en;
  logic [BLK_WIDTH-1:0] w_blk_next;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_abort    = i_abort && (r_state inside {S_LOAD, S_RUN, S_DRAIN});
  // A word arriving in the abort cycle belongs to a cancelled job and is dropped.
  assign w_wr_en    = i_pipe_valid && !i_abort && (r_state inside {S_RUN, S_DRAIN});
  assign w_blk_next = r_blk_cnt + BLK_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_num_blocks  <= '0;
      r_blk_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_flush_cnt   <= 1'b0;
      r_pipe_enable <= 1'b0;
      r_pipe_flush  <= 1'b0;
      r_img_sel     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_irq         <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_abort) begin
        r_state       <= S_FLUSH;
        r_pipe_flush  <= 1'b1;
        r_pipe_enable <= 1'b0;
        r_flush_cnt   <= 1'b0;
        r_irq         <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state       <= S_LOAD;
              r_img_sel     <= i_img_sel;
              r_num_blocks  <= i_num_blocks;
              r_blk_cnt     <= '0;
              r_tmo_cnt     <= '0;
              r_idle_cnt    <= '0;
              r_done        <= 1'b0;
              r_err_timeout <= 1'b0;
              r_busy        <= 1'b1;
              r_pipe_flush  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_pipe_flush <= 1'b0;
            if (r_num_blocks == '0) begin
              r_state <= S_DONE;
              r_irq   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state       <= S_RUN;
              r_pipe_enable <= 1'b1;
            end
          end
          S_RUN: begin
            if (i_blk_valid) begin
              r_blk_cnt <= w_blk_next;
              r_tmo_cnt <= '0;
              if (w_blk_next == r_num_blocks) begin
                r_state       <= S_DRAIN;
                r_pipe_enable <= 1'b0;
                r_idle_cnt    <= '0;
              end
            end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              r_err_timeout <= 1'b1;
              r_state       <= S_DRAIN;
              r_pipe_enable <= 1'b0;
              r_idle_cnt    <= '0;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          S_DRAIN: begin
            // Drain ends only after DRAIN_IDLE quiet cycles spent inside DRAIN.
            if (i_pipe_valid) begin
              r_idle_cnt <= '0;
            end else if (r_idle_cnt == IDLE_W'(DRAIN_IDLE - 1)) begin
              r_state <= S_DONE;
              r_irq   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          S_FLUSH: begin
            if (r_flush_cnt) begin
              r_state      <= S_IDLE;
              r_pipe_flush <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_flush_cnt <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  compression_wr_addr_gen #(
    .AHB_WIDTH  (AHB_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_addr_gen (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_accept),
    .i_wr_en      (w_wr_en),
    .i_data       (i_pipe_data),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_word_count (o_word_count),
    .o_overflow   (o_err_overflow)
  );

  assign o_pipe_enable  = r_pipe_enable;
  assign o_pipe_flush   = r_pipe_flush;
  assign o_pipe_img_sel = r_img_sel;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_irq          = r_irq;
  assign o_err_timeout  = r_err_timeout;
  assign o_dbg_state    = r_state;

endmodule
